// File: rtl/sys_ctrl_gen2_pkg.sv
// rtl/sys_ctrl_gen2_pkg.sv - controller states, command opcodes and state helpers
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OPER_A, OPER_B, ALU_FUN, ALU_WAIT, TX_SEND
  } state_t;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  // States inside a frame that are guarded by the inter-byte timeout
  function automatic logic is_timed(input state_t s);
    return (s != IDLE) && (s != TX_SEND);
  endfunction

endpackage

// File: rtl/sys_ctrl_gen2_if.sv
// rtl/sys_ctrl_gen2_if.sv - controller bus towards UART, register file, ALU and TX FIFO
interface sys_ctrl_gen2_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int ALU_OUT_W = 16,
  parameter int FUN_W     = 4
);
  logic [DATA_W-1:0]    RX_P_DATA;
  logic                 RX_D_VLD;
  logic [DATA_W-1:0]    RdData;
  logic                 RdData_Valid;
  logic [ALU_OUT_W-1:0] ALU_OUT;
  logic                 OUT_VALID;
  logic                 wfull;
  logic [FUN_W-1:0]     ALU_FUN;
  logic                 ALU_EN;
  logic                 CLK_EN;
  logic [ADDR_W-1:0]    Address;
  logic                 WrEn;
  logic                 RdEn;
  logic [DATA_W-1:0]    WrData;
  logic [DATA_W-1:0]    TX_P_DATA;
  logic                 TX_D_VLD;
  logic                 clk_div_en;
  logic                 CMD_ERR;
  logic                 BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, wfull,
    output ALU_FUN, ALU_EN, CLK_EN, Address, WrEn, RdEn, WrData,
           TX_P_DATA, TX_D_VLD, clk_div_en, CMD_ERR, BUSY
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, wfull,
    input  ALU_FUN, ALU_EN, CLK_EN, Address, WrEn, RdEn, WrData,
           TX_P_DATA, TX_D_VLD, clk_div_en, CMD_ERR, BUSY
  );
endinterface

// File: rtl/sys_ctrl_gen2_byte_serializer.sv
// rtl/sys_ctrl_gen2_byte_serializer.sv - result buffer streamed LSB byte first with FIFO-full stall
module byte_serializer #(
  parameter int DATA_W    = 8,
  parameter int ALU_OUT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_load,
  input  logic                 i_wide,
  input  logic [ALU_OUT_W-1:0] i_data,
  input  logic                 i_wfull,
  output logic [DATA_W-1:0]    o_tx_data,
  output logic                 o_tx_vld,
  output logic                 o_done
);
  localparam int NBYTES = ALU_OUT_W / DATA_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [ALU_OUT_W-1:0] r_buf;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_last;
  logic                 r_active;
  logic [ALU_OUT_W-1:0] w_shift;

  // r_last holds nbytes-1 so the end-of-burst compare stays at index width
  assign w_shift   = r_buf >> (DATA_W * int'(r_idx));
  assign o_tx_data = r_active ? w_shift[DATA_W-1:0] : '0;
  assign o_tx_vld  = r_active & ~i_wfull;
  assign o_done    = o_tx_vld & (r_idx == r_last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_buf    <= '0;
      r_idx    <= '0;
      r_last   <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_buf    <= i_data;
      r_idx    <= '0;
      r_last   <= i_wide ? IDX_W'(NBYTES - 1) : '0;
      r_active <= 1'b1;
    end else if (o_tx_vld) begin
      if (o_done) begin
        r_idx    <= '0;
        r_active <= 1'b0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: rtl/sys_ctrl_gen2.sv
// rtl/sys_ctrl_gen2.sv - framed byte command decoder driving register file, ALU and TX FIFO
module sys_ctrl_gen2
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int ALU_OUT_W   = 16,
  parameter int FUN_W       = 4,
  parameter int OPA_ADDR    = 0,
  parameter int OPB_ADDR    = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic           CLK,
  input  logic           RST,
  sys_ctrl_gen2_if.master bus
);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_addr;
  logic [FUN_W-1:0]     r_fun;
  logic [TMO_W-1:0]     r_tmo;
  logic                 w_event;
  logic                 w_tmo_hit;
  logic                 w_load;
  logic                 w_wide;
  logic                 w_done;
  logic [ALU_OUT_W-1:0] w_load_data;

  // Any strobe counts as activity; expiry fires on the TIMEOUT_CYC-th quiet cycle
  assign w_event   = bus.RX_D_VLD | bus.RdData_Valid | bus.OUT_VALID;
  assign w_tmo_hit = (TIMEOUT_CYC != 0) && is_timed(r_state) && !w_event &&
                     (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

  assign w_wide      = (r_state == ALU_WAIT);
  assign w_load      = ((r_state == RD_WAIT) && bus.RdData_Valid) ||
                       ((r_state == ALU_WAIT) && bus.OUT_VALID);
  assign w_load_data = w_wide ? bus.ALU_OUT : ALU_OUT_W'(bus.RdData);

  assign bus.ALU_FUN = r_fun;
  assign bus.BUSY    = (r_state != IDLE);

  byte_serializer #(.DATA_W(DATA_W), .ALU_OUT_W(ALU_OUT_W)) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_load),
    .i_wide    (w_wide),
    .i_data    (w_load_data),
    .i_wfull   (bus.wfull),
    .o_tx_data (bus.TX_P_DATA),
    .o_tx_vld  (bus.TX_D_VLD),
    .o_done    (w_done)
  );

  always_comb begin
    w_next         = r_state;
    bus.ALU_EN     = 1'b0;
    bus.CLK_EN     = 1'b0;
    bus.Address    = '0;
    bus.WrEn       = 1'b0;
    bus.RdEn       = 1'b0;
    bus.WrData     = '0;
    bus.clk_div_en = 1'b0;
    bus.CMD_ERR    = 1'b0;
    case (r_state)
      IDLE: begin
        bus.clk_div_en = 1'b1;
        if (bus.RX_D_VLD) begin
          if      (bus.RX_P_DATA == DATA_W'(OP_WR))      w_next = WR_ADDR;
          else if (bus.RX_P_DATA == DATA_W'(OP_RD))      w_next = RD_ADDR;
          else if (bus.RX_P_DATA == DATA_W'(OP_ALU_OP))  w_next = OPER_A;
          else if (bus.RX_P_DATA == DATA_W'(OP_ALU_NOP)) w_next = ALU_FUN;
          else                                           bus.CMD_ERR = 1'b1;
        end
      end
      WR_ADDR: if (bus.RX_D_VLD) w_next = WR_DATA;
      WR_DATA: if (bus.RX_D_VLD) begin
        bus.WrEn    = 1'b1;
        bus.Address = r_addr;
        bus.WrData  = bus.RX_P_DATA;
        w_next      = IDLE;
      end
      RD_ADDR: if (bus.RX_D_VLD) begin
        bus.RdEn    = 1'b1;
        bus.Address = bus.RX_P_DATA[ADDR_W-1:0];
        w_next      = RD_WAIT;
      end
      RD_WAIT: if (bus.RdData_Valid) w_next = TX_SEND;
      OPER_A, OPER_B: if (bus.RX_D_VLD) begin
        bus.WrEn    = 1'b1;
        bus.Address = (r_state == OPER_A) ? ADDR_W'(OPA_ADDR) : ADDR_W'(OPB_ADDR);
        bus.WrData  = bus.RX_P_DATA;
        w_next      = (r_state == OPER_A) ? OPER_B : ALU_FUN;
      end
      ALU_FUN: begin
        bus.CLK_EN = 1'b1;
        if (bus.RX_D_VLD) w_next = ALU_WAIT;
      end
      ALU_WAIT: begin
        bus.CLK_EN = 1'b1;
        bus.ALU_EN = 1'b1;
        if (bus.OUT_VALID) w_next = TX_SEND;
      end
      TX_SEND: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_tmo_hit) begin
      w_next      = IDLE;
      bus.CMD_ERR = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_fun   <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == WR_ADDR) && bus.RX_D_VLD) r_addr <= bus.RX_P_DATA[ADDR_W-1:0];
      if ((r_state == ALU_FUN) && bus.RX_D_VLD) r_fun  <= bus.RX_P_DATA[FUN_W-1:0];
      if ((w_next != r_state) || w_event)       r_tmo  <= '0;
      else if (is_timed(r_state))               r_tmo  <= r_tmo + TMO_W'(1);
    end
  end
endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// tb/tb_sys_ctrl_gen2.sv - directed bench: 16-bit default instance plus 32-bit, 20-cycle-timeout instance
module tb_sys_ctrl_gen2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu32 = '0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];

  always #5 clk = ~clk;

  sys_ctrl_gen2_if #(.DATA_W(8), .ADDR_W(4), .ALU_OUT_W(16), .FUN_W(4)) ifa ();
  sys_ctrl_gen2_if #(.DATA_W(8), .ADDR_W(4), .ALU_OUT_W(32), .FUN_W(4)) ifb ();

  sys_ctrl_gen2 #(.ALU_OUT_W(16)) u_a (.CLK(clk), .RST(rst_n), .bus(ifa));
  sys_ctrl_gen2 #(.ALU_OUT_W(32), .TIMEOUT_CYC(20)) u_b (.CLK(clk), .RST(rst_n), .bus(ifb));

  assign ifa.ALU_OUT      = alu32[15:0];
  assign ifb.ALU_OUT      = alu32;
  assign ifb.RX_P_DATA    = ifa.RX_P_DATA;
  assign ifb.RX_D_VLD     = ifa.RX_D_VLD;
  assign ifb.RdData       = ifa.RdData;
  assign ifb.RdData_Valid = ifa.RdData_Valid;
  assign ifb.OUT_VALID    = ifa.OUT_VALID;
  assign ifb.wfull        = ifa.wfull;

  // FIFO side: record every byte the FIFO would accept
  always @(negedge clk) begin
    if (ifa.TX_D_VLD) qa.push_back(ifa.TX_P_DATA);
    if (ifb.TX_D_VLD) qb.push_back(ifb.TX_P_DATA);
  end

  function automatic logic [31:0] outs_a();
    return {ifa.ALU_FUN, ifa.ALU_EN, ifa.CLK_EN, ifa.Address, ifa.WrEn, ifa.RdEn, ifa.WrData,
            ifa.TX_P_DATA, ifa.TX_D_VLD, ifa.clk_div_en, ifa.CMD_ERR, ifa.BUSY};
  endfunction

  function automatic logic [31:0] outs_b();
    return {ifb.ALU_FUN, ifb.ALU_EN, ifb.CLK_EN, ifb.Address, ifb.WrEn, ifb.RdEn, ifb.WrData,
            ifb.TX_P_DATA, ifb.TX_D_VLD, ifb.clk_div_en, ifb.CMD_ERR, ifb.BUSY};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_on(input logic [7:0] b);
    ifa.RX_P_DATA = b;
    ifa.RX_D_VLD  = 1'b1;
    @(negedge clk);
  endtask

  task automatic rx_off();
    tick();
    ifa.RX_D_VLD = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  initial begin
    int cnt;
    ifa.RX_P_DATA = '0; ifa.RX_D_VLD = 1'b0; ifa.RdData = '0; ifa.RdData_Valid = 1'b0;
    ifa.OUT_VALID = 1'b0; ifa.wfull = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs_a", outs_a(), 32'h0000_0004);
    chk("reset_outs_b", outs_b(), 32'h0000_0004);
    tick();
    rst_n = 1'b1;

    // register write
    rx_on(8'hAA); chk("wr_op_busy", {31'd0, ifa.BUSY}, 0); rx_off();
    rx_on(8'h05); chk("wr_addr_nowr", {31'd0, ifa.WrEn}, 0); rx_off();
    rx_on(8'h3C);
    chk("wr_data_bus", {ifa.WrEn, ifa.Address, ifa.WrData}, {1'b1, 4'h5, 8'h3C});
    rx_off();
    @(negedge clk);
    chk("wr_done_idle", {ifa.BUSY, ifa.WrEn}, 2'b00);

    // register read with FIFO backpressure
    tick();
    rx_on(8'hBB); rx_off();
    rx_on(8'h07); chk("rd_strobe", {ifa.RdEn, ifa.Address}, {1'b1, 4'h7}); rx_off();
    ifa.RdData = 8'h5A; ifa.RdData_Valid = 1'b1; ifa.wfull = 1'b1;
    @(negedge clk);
    chk("rd_wait_novld", {31'd0, ifa.TX_D_VLD}, 0);
    tick();
    ifa.RdData_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rd_stall", {ifa.TX_D_VLD, ifa.BUSY}, 2'b01);
    end
    tick();
    ifa.wfull = 1'b0;
    repeat (4) tick();
    chk("rd_push_count", qa.size(), 1);
    chk("rd_push_data", {24'd0, qa[0]}, 32'h5A);
    chk("rd_done_idle", {31'd0, ifa.BUSY}, 0);
    do_reset();

    // ALU with operands, 16-bit result
    rx_on(8'hCC); rx_off();
    rx_on(8'h0A); chk("opa_write", {ifa.WrEn, ifa.Address, ifa.WrData}, {1'b1, 4'h0, 8'h0A}); rx_off();
    rx_on(8'h03); chk("opb_write", {ifa.WrEn, ifa.Address, ifa.WrData}, {1'b1, 4'h1, 8'h03}); rx_off();
    rx_on(8'h00); chk("alufun_gate", {ifa.CLK_EN, ifa.ALU_EN, ifa.WrEn}, 3'b100); rx_off();
    @(negedge clk);
    chk("aluwait_en", {ifa.ALU_FUN, ifa.CLK_EN, ifa.ALU_EN}, {4'h0, 2'b11});
    alu32 = 32'h0000_000D; ifa.OUT_VALID = 1'b1;
    tick();
    ifa.OUT_VALID = 1'b0;
    repeat (4) tick();
    chk("alu_push_count", qa.size(), 2);
    chk("alu_push_bytes", {16'd0, qa[0], qa[1]}, 32'h0000_0D00);
    chk("alu_done_idle", {31'd0, ifa.BUSY}, 0);
    do_reset();

    // function-only ALU, 32-bit result, FIFO full every other cycle
    rx_on(8'hDD); chk("nop_op_busy", {31'd0, ifb.BUSY}, 0); rx_off();
    rx_on(8'h05); rx_off();
    @(negedge clk);
    chk("wide_fun_en", {ifb.ALU_FUN, ifb.ALU_EN}, {4'h5, 1'b1});
    alu32 = 32'hDEAD_BEEF; ifa.OUT_VALID = 1'b1;
    tick();
    ifa.OUT_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ifa.wfull = (i % 2) == 1;
      tick();
    end
    ifa.wfull = 1'b0;
    repeat (2) tick();
    chk("wide_push_count", qb.size(), 4);
    chk("wide_push_bytes", {qb[0], qb[1], qb[2], qb[3]}, 32'hEFBE_ADDE);
    chk("wide_done_idle", {31'd0, ifb.BUSY}, 0);
    do_reset();

    // unknown opcode
    rx_on(8'h77); chk("bad_op_err", {ifb.CMD_ERR, ifb.BUSY, ifa.CMD_ERR}, 3'b101); rx_off();
    @(negedge clk);
    chk("bad_op_after", {ifb.CMD_ERR, ifb.BUSY}, 2'b00);

    // inter-byte timeout on the 20-cycle instance
    tick();
    rx_on(8'hAA); rx_off();
    cnt = 0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (ifb.CMD_ERR || ifb.WrEn || !ifb.BUSY) cnt++;
    end
    chk("tmo_early_quiet", cnt, 0);
    @(negedge clk);
    chk("tmo_expire", {ifb.CMD_ERR, ifb.WrEn, ifb.RdEn, ifb.BUSY}, 4'b1001);
    @(negedge clk);
    chk("tmo_back_idle", {ifb.CMD_ERR, ifb.BUSY, ifb.clk_div_en}, 3'b001);
    do_reset();

    // reset in the middle of an ALU frame
    rx_on(8'hCC); rx_off();
    rx_on(8'h11); rx_off();
    @(negedge clk);
    chk("mid_frame_busy", {31'd0, ifa.BUSY}, 1);
    tick();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_outs_a", outs_a(), 32'h0000_0004);
    chk("mid_rst_outs_b", outs_b(), 32'h0000_0004);
    tick();
    rst_n = 1'b1;
    rx_on(8'hAA); rx_off();
    rx_on(8'h02); rx_off();
    rx_on(8'h99);
    chk("post_rst_write", {ifa.WrEn, ifa.Address, ifa.WrData}, {1'b1, 4'h2, 8'h99});
    rx_off();
    @(negedge clk);
    chk("post_rst_idle", {31'd0, ifa.BUSY}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sys_ctrl_gen2.md
Name: sys_ctrl_gen2

Overview:
Parametrised second-generation command controller between the UART RX/TX path, the register file, the ALU and the TX async FIFO. It decodes framed byte commands: register write, register read, ALU with operands, and ALU function-only. It then streams results into the TX FIFO. New in this generation:
- ALU result of any whole-byte width
- lossless FIFO backpressure (stall, never drop)
- inter-byte timeout
- error reporting for unknown opcodes and timeouts

Parameters:
DATA_W, 8, byte width of RX/TX/register data
ADDR_W, 4, register file address width
ALU_OUT_W, 16, ALU result width; must be a multiple of DATA_W
FUN_W, 4, ALU function code width
OPA_ADDR, 0, register address for operand A
OPB_ADDR, 1, register address for operand B
TIMEOUT_CYC, 1023, idle cycles allowed inside a frame; 0 disables the timeout

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_W  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
RdData  in  DATA_W  register file read data
RdData_Valid  in  1  read data valid strobe
ALU_OUT  in  ALU_OUT_W  ALU result
OUT_VALID  in  1  ALU result valid
wfull  in  1  TX FIFO full
ALU_FUN  out  FUN_W  registered ALU function code
ALU_EN  out  1  ALU enable
CLK_EN  out  1  ALU clock-gate enable
Address  out  ADDR_W  register file address
WrEn  out  1  register write enable
RdEn  out  1  register read enable
WrData  out  DATA_W  register write data
TX_P_DATA  out  DATA_W  byte pushed to the TX FIFO
TX_D_VLD  out  1  FIFO push strobe
clk_div_en  out  1  clock divider enable
CMD_ERR  out  1  one-cycle error pulse
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; addr_reg, fun_reg, res_buf, byte_idx and timeout counter cleared. All outputs are 0 except clk_div_en=1.
- Outputs are combinational from the state and inputs; all internal registers update on the CLK rising edge.
- Opcodes are package constants: WR=0xAA, RD=0xBB, ALU_OP=0xCC, ALU_NOP=0xDD.
- IDLE: clk_div_en=1. On RX_D_VLD:
  - WR → WR_ADDR
  - RD → RD_ADDR
  - ALU_OP → OPER_A
  - ALU_NOP → ALU_FUN
  - any other value → CMD_ERR=1 for that cycle, stay in IDLE.
- WR_ADDR: on RX_D_VLD, addr_reg<=RX_P_DATA[ADDR_W-1:0] → WR_DATA.
- WR_DATA: on RX_D_VLD, same cycle WrEn=1, Address=addr_reg, WrData=RX_P_DATA → IDLE.
- RD_ADDR: on RX_D_VLD, same cycle RdEn=1, Address=RX_P_DATA[ADDR_W-1:0] → RD_WAIT.
- RD_WAIT: on RdData_Valid, res_buf[DATA_W-1:0]<=RdData, nbytes<=1, byte_idx<=0 → TX_SEND.
- OPER_A: on RX_D_VLD, WrEn=1, Address=OPA_ADDR, WrData=RX_P_DATA → OPER_B.
- OPER_B: same as OPER_A with Address=OPB_ADDR → ALU_FUN.
- ALU_FUN: CLK_EN=1, ALU_EN=0. On RX_D_VLD, fun_reg<=RX_P_DATA[FUN_W-1:0] → ALU_WAIT.
- ALU_FUN port always equals fun_reg, so it is stable before ALU_EN rises.
- ALU_WAIT: CLK_EN=1, ALU_EN=1. On OUT_VALID, res_buf<=ALU_OUT, nbytes<=ALU_OUT_W/DATA_W, byte_idx<=0 → TX_SEND.
- TX_SEND:
  - TX_P_DATA=res_buf[byte_idx*DATA_W +: DATA_W], sent LSB byte first.
  - TX_D_VLD=!wfull; a byte is consumed only when TX_D_VLD=1.
  - While wfull=1, hold state and byte_idx; no byte is lost or duplicated.
  - After the push of byte nbytes-1 → IDLE. No timeout applies in TX_SEND.
- Timeout applies in WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPER_A, OPER_B, ALU_FUN and ALU_WAIT:
  - The counter clears on state entry and on each RX_D_VLD, RdData_Valid or OUT_VALID; otherwise it increments.
  - When it reaches TIMEOUT_CYC → IDLE with CMD_ERR=1 for one cycle. No WrEn or RdEn is issued on that cycle.
- RX_D_VLD in RD_WAIT, ALU_WAIT or TX_SEND is ignored; no queueing.
- Simultaneous RX_D_VLD and timeout expiry: RX_D_VLD wins and the counter clears.
- Reset asserted mid-frame: return to IDLE immediately; no partial write is issued.

Decomposition:
- Package sys_ctrl_pkg: state enum (IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPER_A, OPER_B, ALU_FUN, ALU_WAIT, TX_SEND) and the opcode localparams.
- One sub-module, byte_serializer: owns res_buf, nbytes, byte_idx and the wfull-stall logic. Interfaces:
  - load strobe + width select in
  - TX_P_DATA/TX_D_VLD out
  - done pulse out
- The FSM and the timeout counter stay in the top module.

Test Plan:
- Write: RX 0xAA, 0x05, 0x3C → one cycle WrEn=1, Address=5, WrData=0x3C; then IDLE, BUSY=0.
- Read with backpressure: preload reg 7=0x5A; RX 0xBB, 0x07; wfull=1 for 10 cycles after RdData_Valid → TX_D_VLD stays 0, then exactly one push of 0x5A.
- ALU op: RX 0xCC, 0x0A, 0x03, 0x00; ALU_OUT=0x000D → writes reg0=0x0A and reg1=0x03; ALU_FUN=0 before ALU_EN; pushes 0x0D then 0x00.
- Wide result: ALU_OUT_W=32, ALU_OUT=0xDEADBEEF, wfull toggling every cycle → pushes EF, BE, AD, DE in order with no duplicates.
- Errors:
  - RX 0x77 → CMD_ERR pulse, stays IDLE.
  - TIMEOUT_CYC=20; RX 0xAA then silence → CMD_ERR at cycle 20, IDLE, no WrEn.
- Reset mid-frame: RX 0xCC, 0x11, then RST low → all outputs at reset values, clk_div_en=1; next 0xAA frame completes normally.
